// File: rtl/iserdes_bitslip_trainer.sv
// rtl/iserdes_bitslip_trainer.sv - ISERDES2 bitslip word-alignment trainer
//
// Purpose: compares the deserialized word against a fixed training pattern,
// pulses bitslip until the pattern is seen for MATCH_COUNT consecutive words,
// then reports lock and counts mismatched words until retrained.
//
// Ports:
//   clkdiv      in   sole clock (ISERDES CLKDIV domain), posedge
//   rst_n       in   asynchronous active-low reset
//   start       in   single-cycle request to begin/restart training
//   data        in   deserialized word {Q4..Q1}, LSB = Q1
//   bitslip     out  one-cycle slip pulse to ISERDES2 BITSLIP
//   busy        out  training in progress
//   locked      out  alignment achieved
//   fail        out  slip budget exhausted without lock
//   slip_count  out  bitslip pulses issued in the current training run
//   err_count   out  mismatched words seen while locked, saturating at 255
module iserdes_bitslip_trainer #(
  parameter int                    DATA_WIDTH    = 4,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 4'hC,
  parameter int                    SETTLE_CYCLES = 3,
  parameter int                    MATCH_COUNT   = 16,
  parameter int                    MAX_SLIPS     = 8
) (
  input  logic                  clkdiv,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  bitslip,
  output logic                  busy,
  output logic                  locked,
  output logic                  fail,
  output logic [3:0]            slip_count,
  output logic [7:0]            err_count
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int MW = (MATCH_COUNT > 1) ? $clog2(MATCH_COUNT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_SLIP,
    S_LOCK,
    S_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [MW-1:0] match_q, match_d;
  logic [3:0]    slip_d;
  logic [7:0]    err_d;
  logic          bitslip_d, busy_d, locked_d, fail_d;

  // Output flags are computed for the state being entered and registered,
  // so every flag is glitch-free and lines up with the registered state.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    match_d   = match_q;
    slip_d    = slip_count;
    err_d     = err_count;
    bitslip_d = 1'b0;
    busy_d    = 1'b0;
    locked_d  = 1'b0;
    fail_d    = 1'b0;

    case (state_q)
      S_SETTLE: begin
        busy_d = 1'b1;
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          state_d = S_CHECK;
          match_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_CHECK: begin
        busy_d = 1'b1;
        if (data == TRAIN_PATTERN) begin
          if (match_q == MW'(MATCH_COUNT - 1)) begin
            state_d  = S_LOCK;
            busy_d   = 1'b0;
            locked_d = 1'b1;
          end else begin
            match_d = match_q + 1'b1;
          end
        end else if (slip_count == 4'(MAX_SLIPS)) begin
          state_d = S_FAIL;
          busy_d  = 1'b0;
          fail_d  = 1'b1;
        end else begin
          // slip_count advances together with the pulse it counts
          state_d   = S_SLIP;
          bitslip_d = 1'b1;
          slip_d    = slip_count + 1'b1;
        end
      end
      S_SLIP: begin
        busy_d   = 1'b1;
        state_d  = S_SETTLE;
        settle_d = '0;
      end
      S_LOCK: begin
        locked_d = 1'b1;
        if (data != TRAIN_PATTERN && err_count != 8'hFF) begin
          err_d = err_count + 1'b1;
        end
      end
      S_FAIL: begin
        fail_d = 1'b1;
      end
      default: begin
      end
    endcase

    // start is honoured only outside an active training run
    if (start && (state_q == S_IDLE || state_q == S_LOCK || state_q == S_FAIL)) begin
      state_d   = S_SETTLE;
      settle_d  = '0;
      match_d   = '0;
      slip_d    = '0;
      err_d     = '0;
      bitslip_d = 1'b0;
      busy_d    = 1'b1;
      locked_d  = 1'b0;
      fail_d    = 1'b0;
    end
  end

  always_ff @(posedge clkdiv or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      settle_q   <= '0;
      match_q    <= '0;
      slip_count <= '0;
      err_count  <= '0;
      bitslip    <= 1'b0;
      busy       <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      match_q    <= match_d;
      slip_count <= slip_d;
      err_count  <= err_d;
      bitslip    <= bitslip_d;
      busy       <= busy_d;
      locked     <= locked_d;
      fail       <= fail_d;
    end
  end

endmodule

// File: tb/tb_iserdes_bitslip_trainer.sv
// tb/tb_iserdes_bitslip_trainer.sv - self-checking bench for iserdes_bitslip_trainer
module tb_iserdes_bitslip_trainer;

  localparam int         W    = 4;
  localparam logic [3:0] PAT  = 4'hC;
  localparam int         S    = 3;
  localparam int         M    = 16;
  localparam int         MAXS = 8;
  localparam int         RUN  = 240;
  localparam int         NTBL = 30;

  logic       clkdiv = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start  = 1'b0;
  logic [3:0] data   = 4'h0;
  logic       bitslip, busy, locked, fail;
  logic [3:0] slip_count;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clkdiv = ~clkdiv;

  iserdes_bitslip_trainer #(
    .DATA_WIDTH   (W),
    .TRAIN_PATTERN(PAT),
    .SETTLE_CYCLES(S),
    .MATCH_COUNT  (M),
    .MAX_SLIPS    (MAXS)
  ) dut (
    .clkdiv    (clkdiv),
    .rst_n     (rst_n),
    .start     (start),
    .data      (data),
    .bitslip   (bitslip),
    .busy      (busy),
    .locked    (locked),
    .fail      (fail),
    .slip_count(slip_count),
    .err_count (err_count)
  );

  typedef struct {
    bit       st;
    bit [3:0] d;
    bit       bs, bz, lk, fl;
    int       sc, ec;
  } vec_t;

  vec_t       tbl[NTBL];
  logic [3:0] rd[RUN];
  bit         e_bz[RUN], e_lk[RUN], e_fl[RUN], e_bs[RUN];
  int         e_sc[RUN], e_ec[RUN];

  task automatic check_out(input string name, input bit ebs, input bit ebz, input bit elk,
                           input bit efl, input int esc, input int eec);
    logic [15:0] got, want;
    got  = {bitslip, busy, locked, fail, slip_count, err_count};
    want = {ebs, ebz, elk, efl, 4'(esc), 8'(eec)};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got bs=%b busy=%b lock=%b fail=%b slip=%0d err=%0d, want bs=%b busy=%b lock=%b fail=%b slip=%0d err=%0d",
               name, bitslip, busy, locked, fail, slip_count, err_count, ebs, ebz, elk, efl, esc, eec);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // drive inputs at a falling edge; return at the next falling edge, where the
  // outputs reflect the rising edge that sampled these inputs
  task automatic cyc(input bit st, input logic [3:0] d);
    start = st;
    data  = d;
    @(negedge clkdiv);
  endtask

  task automatic do_reset();
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clkdiv);
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] rotl(input logic [3:0] v, input int n);
    logic [7:0] t;
    t = {v, v} << n;
    return t[7:4];
  endfunction

  task automatic mark(input int q, input int s);
    if (q < RUN) begin
      e_bz[q] = 1'b1;
      e_sc[q] = s;
    end
  endtask

  // Timeline reference: period q is the cycle following the edge that
  // consumed rd[q]; start is given with rd[0]. Each attempt skips S words,
  // then scans a run of matching words; M matches lock, a shorter run costs
  // one slip (or ends in fail when the budget is spent).
  task automatic build_model();
    int p, k, slips, t, err;
    bit lock_end;
    for (int q = 0; q < RUN; q++) begin
      e_bz[q] = 0; e_lk[q] = 0; e_fl[q] = 0; e_bs[q] = 0; e_sc[q] = 0; e_ec[q] = 0;
    end
    slips = 0; p = S; t = -1; lock_end = 0;
    for (int q = 0; q < S; q++) mark(q, 0);
    while (t < 0 && p < RUN) begin
      k = 0;
      while (k < M && p + 1 + k < RUN && rd[p+1+k] == PAT) k++;
      if (k == M) begin
        for (int q = p; q < p + M; q++) mark(q, slips);
        t = p + M;
        lock_end = 1;
      end else if (p + 1 + k >= RUN) begin
        for (int q = p; q < RUN; q++) mark(q, slips);
        p = RUN;
      end else begin
        for (int q = p; q <= p + k; q++) mark(q, slips);
        if (slips == MAXS) begin
          t = p + k + 1;
        end else begin
          slips++;
          for (int q = p + k + 1; q <= p + k + 1 + S; q++) mark(q, slips);
          if (p + k + 1 < RUN) e_bs[p+k+1] = 1;
          p = p + k + 2 + S;
        end
      end
    end
    if (t >= 0) begin
      err = 0;
      for (int q = t; q < RUN; q++) begin
        if (lock_end && q > t && rd[q] != PAT && err < 255) err++;
        e_lk[q] = lock_end;
        e_fl[q] = !lock_end;
        e_sc[q] = slips;
        e_ec[q] = lock_end ? err : 0;
      end
    end
  endtask

  initial begin
    int pulses, viol, min_gap, last_bs, lock_p, slip_p, fail_p, off;
    bit prev;

    // vector table: clean lock from reset, then three isolated bad words
    for (int i = 0; i < NTBL; i++) begin
      tbl[i].st = (i == 0);
      tbl[i].d  = (i == 22 || i == 24 || i == 26) ? 4'h0 : PAT;
      tbl[i].bs = 0;
      tbl[i].bz = (i < S + M);
      tbl[i].lk = (i >= S + M);
      tbl[i].fl = 0;
      tbl[i].sc = 0;
      tbl[i].ec = (i >= 26) ? 3 : (i >= 24) ? 2 : (i >= 22) ? 1 : 0;
    end

    @(negedge clkdiv);
    @(negedge clkdiv);
    check_out("reset_state", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, PAT);
    check_out("idle_no_start", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < NTBL; i++) begin
      cyc(tbl[i].st, tbl[i].d);
      check_out($sformatf("table[%0d]", i), tbl[i].bs, tbl[i].bz, tbl[i].lk, tbl[i].fl,
                tbl[i].sc, tbl[i].ec);
    end

    for (int i = 0; i < 300; i++) cyc(0, 4'h0);
    check_out("err_saturate", 0, 0, 1, 0, 0, 255);
    cyc(1, PAT);
    check_out("restart_from_lock", 0, 1, 0, 0, 0, 0);

    // asynchronous reset in the middle of SETTLE, between clock edges
    cyc(0, 4'h5);
    #1 data = 4'hA;
    #1 rst_n = 1'b0;
    #1 check_out("async_reset_mid_settle", 0, 0, 0, 0, 0, 0);
    data = 4'h3;
    @(negedge clkdiv);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cyc(0, 4'($urandom_range(15)));
    check_out("idle_after_reset", 0, 0, 0, 0, 0, 0);

    // serial link whose word boundary moves one bit per slip, offset 2
    do_reset();
    off = 2; pulses = 0; viol = 0; min_gap = 1000; last_bs = -1; lock_p = -1; prev = 0;
    cyc(1, rotl(PAT, off));
    for (int p = 0; p < 200 && lock_p < 0; p++) begin
      if (bitslip) begin
        pulses++;
        if (prev) viol++;
        if (last_bs >= 0 && p - last_bs < min_gap) min_gap = p - last_bs;
        last_bs = p;
        off = (off + W - 1) % W;
      end
      prev = bitslip;
      if (locked) lock_p = p;
      else cyc(0, rotl(PAT, off));
    end
    check_int("serial_pulses", pulses, 2);
    check_int("serial_back_to_back", viol, 0);
    check_int("serial_gap_ok", int'(min_gap >= S + 2), 1);
    check_int("serial_lock_cycle", lock_p, 2 * (S + 2) + S + M);
    check_out("serial_locked", 0, 0, 1, 0, 2, 0);

    // one bad word at the 10th CHECK, start pulses during the run are ignored
    do_reset();
    pulses = 0; slip_p = -1; lock_p = -1;
    for (int p = 0; p < 45; p++) begin
      cyc(p == 0 || p == 1 || p == 6 || p == 14 || p == 15, (p == S + 10) ? 4'h0 : PAT);
      if (bitslip) begin
        pulses++;
        slip_p = p;
      end
      if (locked && lock_p < 0) lock_p = p;
    end
    check_int("glitch_pulses", pulses, 1);
    check_int("glitch_slip_cycle", slip_p, S + 10);
    check_int("glitch_lock_cycle", lock_p, S + 10 + 1 + S + M);
    check_out("glitch_locked", 0, 0, 1, 0, 1, 0);

    // data never matches: exhaust the slip budget
    do_reset();
    pulses = 0; viol = 0; fail_p = -1; prev = 0;
    for (int p = 0; p < 80; p++) begin
      cyc(p == 0, 4'h0);
      if (bitslip) begin
        pulses++;
        if (prev) viol++;
      end
      prev = bitslip;
      if (fail && fail_p < 0) fail_p = p;
    end
    check_int("fail_pulses", pulses, MAXS);
    check_int("fail_back_to_back", viol, 0);
    check_int("fail_cycle", fail_p, S + 1 + MAXS * (S + 2));
    check_out("fail_hold", 0, 0, 0, 1, MAXS, 0);
    cyc(1, 4'h0);
    check_out("restart_from_fail", 0, 1, 0, 0, 0, 0);

    // randomized runs against the timeline model
    do_reset();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < RUN; i++)
        rd[i] = ($urandom_range(99) < 93) ? PAT : 4'($urandom_range(15));
      build_model();
      for (int c = 0; c < RUN; c++) begin
        cyc(c == 0, rd[c]);
        check_out($sformatf("rand%0d[%0d]", r, c), e_bs[c], e_bz[c], e_lk[c], e_fl[c],
                  e_sc[c], e_ec[c]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
